// File: rtl/cv32e40p_apu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_apu_arbiter
// Description : Shares one FPU (APU interface) between NUM_CORES cores using
//               round-robin arbitration with one outstanding operation, routes
//               each result back to its issuer, and synthesises a response
//               plus a sticky fault if the FPU never answers.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_apu_arbiter #(
    parameter int NUM_CORES      = 2,
    parameter int NARGS          = 3,
    parameter int WOP            = 6,
    parameter int NDSFLAGS       = 15,
    parameter int NUSFLAGS       = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_CORES-1:0]                  core_req_i,
    output logic [NUM_CORES-1:0]                  core_gnt_o,
    input  logic [NUM_CORES-1:0][NARGS-1:0][31:0] core_operands_i,
    input  logic [NUM_CORES-1:0][WOP-1:0]         core_op_i,
    input  logic [NUM_CORES-1:0][NDSFLAGS-1:0]    core_flags_i,
    output logic [NUM_CORES-1:0]                  core_rvalid_o,
    output logic [31:0]                           core_result_o,
    output logic [NUSFLAGS-1:0]                   core_rflags_o,
    output logic                                  fpu_req_o,
    input  logic                                  fpu_gnt_i,
    output logic [NARGS-1:0][31:0]                fpu_operands_o,
    output logic [WOP-1:0]                        fpu_op_o,
    output logic [NDSFLAGS-1:0]                   fpu_flags_o,
    input  logic                                  fpu_rvalid_i,
    input  logic [31:0]                           fpu_result_i,
    input  logic [NUSFLAGS-1:0]                   fpu_rflags_i,
    input  logic                                  fault_clear_i,
    output logic                                  fpu_fault_o,
    output logic                                  busy_o
);

    localparam int OW = $clog2(NUM_CORES);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST   = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [OW-1:0] LAST_CORE = OW'(NUM_CORES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        BUSY     = 2'd2
    } state_e;

    state_e          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   rr_ptr;
    logic [CW-1:0]   wd_count;
    logic            fault;

    logic [OW-1:0]   rr_winner;
    logic            any_req;
    logic [OW-1:0]   sel;
    logic [OW-1:0]   sel_next;
    logic            req_active;
    logic            wd_fire;
    logic            fault_set;

    // Round-robin pick: first requester at or above rr_ptr, wrapping to 0
    always_comb begin
        int            idx;
        logic [OW-1:0] cand;
        rr_winner = rr_ptr;
        any_req   = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            cand = OW'(idx);
            if (core_req_i[cand]) begin
                rr_winner = cand;
                any_req   = 1'b1;
            end
        end
    end

    // Selected core and whether a request is presented to the FPU this cycle
    always_comb begin
        sel        = (state == IDLE) ? rr_winner : owner;
        sel_next   = (sel == LAST_CORE) ? '0 : sel + OW'(1);
        req_active = 1'b0;
        case (state)
            IDLE:     req_active = any_req;
            WAIT_GNT: req_active = core_req_i[owner];
            default:  req_active = 1'b0;
        endcase
        wd_fire   = (TIMEOUT_CYCLES != 0) && (state == BUSY) && !fpu_rvalid_i
                    && (wd_count == TO_LAST);
        fault_set = ((state != BUSY) && fpu_rvalid_i) || wd_fire;
    end

    // Output steering; everything is forced low while reset is asserted
    always_comb begin
        fpu_req_o      = 1'b0;
        core_gnt_o     = '0;
        core_rvalid_o  = '0;
        core_result_o  = '0;
        core_rflags_o  = '0;
        fpu_operands_o = '0;
        fpu_op_o       = '0;
        fpu_flags_o    = '0;
        if (rst_ni) begin
            fpu_req_o       = req_active;
            core_gnt_o[sel] = req_active & fpu_gnt_i;
            fpu_operands_o  = core_operands_i[sel];
            fpu_op_o        = core_op_i[sel];
            fpu_flags_o     = core_flags_i[sel];
            if (state == BUSY) begin
                core_rvalid_o[owner] = fpu_rvalid_i | wd_fire;
                if (fpu_rvalid_i) begin
                    core_result_o = fpu_result_i;
                    core_rflags_o = fpu_rflags_i;
                end
            end
        end
    end

    assign fpu_fault_o = fault;
    assign busy_o      = (state == BUSY);

    // Arbitration FSM, watchdog counter and sticky fault flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            wd_count <= '0;
            fault    <= 1'b0;
        end else begin
            if (fault_set) begin
                fault <= 1'b1;
            end else if (fault_clear_i) begin
                fault <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= rr_winner;
                        if (fpu_gnt_i) begin
                            rr_ptr   <= sel_next;
                            wd_count <= '0;
                            state    <= BUSY;
                        end else begin
                            state <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (!core_req_i[owner]) begin
                        state <= IDLE;
                    end else if (fpu_gnt_i) begin
                        rr_ptr   <= sel_next;
                        wd_count <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (fpu_rvalid_i || wd_fire) begin
                        state <= IDLE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wd_count <= wd_count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_apu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_apu_arbiter
// Description : Self-checking bench for cv32e40p_apu_arbiter. Directed
//               scenarios followed by randomized traffic, all compared every
//               cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_apu_arbiter;

    localparam int NC  = 3;
    localparam int NA  = 3;
    localparam int WOP = 6;
    localparam int NDS = 15;
    localparam int NUS = 5;
    localparam int TO  = 8;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NC-1:0]                 core_req;
    logic [NC-1:0]                 core_gnt;
    logic [NC-1:0][NA-1:0][31:0]   core_ops;
    logic [NC-1:0][WOP-1:0]        core_op;
    logic [NC-1:0][NDS-1:0]        core_flags;
    logic [NC-1:0]                 core_rvalid;
    logic [31:0]                   core_result;
    logic [NUS-1:0]                core_rflags;
    logic                          fpu_req;
    logic                          fpu_gnt;
    logic [NA-1:0][31:0]           fpu_ops;
    logic [WOP-1:0]                fpu_op;
    logic [NDS-1:0]                fpu_flags;
    logic                          fpu_rvalid;
    logic [31:0]                   fpu_result;
    logic [NUS-1:0]                fpu_rflags;
    logic                          fault_clear;
    logic                          fpu_fault;
    logic                          busy;

    always #5 clk = ~clk;

    cv32e40p_apu_arbiter #(
        .NUM_CORES     (NC),
        .NARGS         (NA),
        .WOP           (WOP),
        .NDSFLAGS      (NDS),
        .NUSFLAGS      (NUS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .core_req_i     (core_req),
        .core_gnt_o     (core_gnt),
        .core_operands_i(core_ops),
        .core_op_i      (core_op),
        .core_flags_i   (core_flags),
        .core_rvalid_o  (core_rvalid),
        .core_result_o  (core_result),
        .core_rflags_o  (core_rflags),
        .fpu_req_o      (fpu_req),
        .fpu_gnt_i      (fpu_gnt),
        .fpu_operands_o (fpu_ops),
        .fpu_op_o       (fpu_op),
        .fpu_flags_o    (fpu_flags),
        .fpu_rvalid_i   (fpu_rvalid),
        .fpu_result_i   (fpu_result),
        .fpu_rflags_i   (fpu_rflags),
        .fault_clear_i  (fault_clear),
        .fpu_fault_o    (fpu_fault),
        .busy_o         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one operation in flight, owner, next-priority core, age
    bit             m_inflight;
    bit             m_pending;
    bit             m_fault;
    int             m_owner;
    int             m_next;
    int             m_age;

    // FPU behaviour for the operation in flight (lat 0 = never answers)
    int             f_lat;
    logic [31:0]    f_res;
    logic [NUS-1:0] f_flags;

    // Scenario controls
    bit             rand_mode;
    bit             hold_req;
    int             d_lat;
    logic [31:0]    d_res;
    logic [NUS-1:0] d_flags;
    logic [NC-1:0]  drop_mask;
    int             busy_seen;
    int             gq[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inflight = 1'b0;
        m_pending  = 1'b0;
        m_fault    = 1'b0;
        m_owner    = 0;
        m_next     = 0;
        m_age      = 0;
        drop_mask  = '0;
    endtask

    // Fresh operand data every cycle, granted requests withdrawn, FPU answers
    task automatic drive_fpu();
        core_req  = core_req & ~drop_mask;
        drop_mask = '0;
        for (int c = 0; c < NC; c++) begin
            for (int a = 0; a < NA; a++) core_ops[c][a] = $urandom;
            core_op[c]    = WOP'($urandom);
            core_flags[c] = NDS'($urandom);
        end
        fpu_rvalid = m_inflight && (f_lat != 0) && (m_age == f_lat);
        fpu_result = fpu_rvalid ? f_res : $urandom;
        fpu_rflags = fpu_rvalid ? f_flags : NUS'($urandom);
    endtask

    task automatic drive_rand();
        drive_fpu();
        for (int c = 0; c < NC; c++) begin
            if (!core_req[c] && ($urandom % 3 == 0)) core_req[c] = 1'b1;
            else if (core_req[c] && ($urandom % 60 == 0)) core_req[c] = 1'b0;
        end
        fpu_gnt     = ($urandom % 4) != 0;
        fault_clear = ($urandom % 12) == 0;
        if (!m_inflight && ($urandom % 40 == 0)) fpu_rvalid = 1'b1;
    endtask

    // Compare one cycle of DUT outputs against the model, then advance it
    task automatic run_cycle();
        int            sel;
        bit            any;
        bit            ereq;
        bit            tmo;
        bit            granted;
        logic [NC-1:0] egnt;
        logic [NC-1:0] ervld;
        #1;
        sel  = 0;
        any  = 1'b0;
        ereq = 1'b0;
        if (!m_inflight) begin
            if (m_pending) begin
                sel  = m_owner;
                ereq = core_req[m_owner];
            end else begin
                for (int k = NC - 1; k >= 0; k--) begin
                    int c;
                    c = (m_next + k) % NC;
                    if (core_req[c]) begin
                        sel = c;
                        any = 1'b1;
                    end
                end
                ereq = any;
            end
        end
        granted = ereq && fpu_gnt;
        egnt = '0;
        if (granted) egnt[sel] = 1'b1;
        tmo = m_inflight && !fpu_rvalid && (m_age == TO);
        ervld = '0;
        if (m_inflight && (fpu_rvalid || tmo)) ervld[m_owner] = 1'b1;

        check("fpu_req", 128'(fpu_req), 128'(ereq));
        check("core_gnt", 128'(core_gnt), 128'(egnt));
        check("core_rvalid", 128'(core_rvalid), 128'(ervld));
        check("busy", 128'(busy), 128'(m_inflight));
        check("fault", 128'(fpu_fault), 128'(m_fault));
        if (ereq) begin
            check("fpu_operands", 128'(fpu_ops), 128'(core_ops[sel]));
            check("fpu_op", 128'(fpu_op), 128'(core_op[sel]));
            check("fpu_flags", 128'(fpu_flags), 128'(core_flags[sel]));
        end
        if (ervld != 0) begin
            check("core_result", 128'(core_result), tmo ? 128'(0) : 128'(fpu_result));
            check("core_rflags", 128'(core_rflags), tmo ? 128'(0) : 128'(fpu_rflags));
        end
        if (busy) busy_seen++;
        for (int c = 0; c < NC; c++) if (core_gnt[c]) gq.push_back(c);

        @(posedge clk);
        if (tmo || (!m_inflight && fpu_rvalid)) m_fault = 1'b1;
        else if (fault_clear) m_fault = 1'b0;
        if (m_inflight) begin
            if (fpu_rvalid || tmo) m_inflight = 1'b0;
            else m_age++;
        end else if (granted) begin
            m_inflight = 1'b1;
            m_pending  = 1'b0;
            m_age      = 1;
            m_owner    = sel;
            m_next     = (sel + 1) % NC;
            if (!hold_req) drop_mask[sel] = 1'b1;
            if (rand_mode) begin
                f_lat   = ($urandom % 8 == 0) ? 0 : 1 + int'($urandom % 8);
                f_res   = $urandom;
                f_flags = NUS'($urandom);
            end else begin
                f_lat   = d_lat;
                f_res   = d_res;
                f_flags = d_flags;
            end
        end else if (m_pending) begin
            if (!core_req[m_owner]) m_pending = 1'b0;
        end else if (any) begin
            m_pending = 1'b1;
            m_owner   = sel;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        core_req = '0; core_ops = '0; core_op = '0; core_flags = '0;
        fpu_gnt = 1'b0; fpu_rvalid = 1'b0; fpu_result = '0; fpu_rflags = '0;
        fault_clear = 1'b0;
        rand_mode = 1'b0; hold_req = 1'b0;
        d_lat = 1; d_res = '0; d_flags = '0;
        f_lat = 0; f_res = '0; f_flags = '0;
        busy_seen = 0;
        model_reset();
        #1 rst_n = 1'b0;
        core_req = 3'b011;
        fpu_gnt  = 1'b1;
        @(negedge clk);
        #1;
        check("rst_fpu_req", 128'(fpu_req), 128'(0));
        check("rst_core_gnt", 128'(core_gnt), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_fault", 128'(fpu_fault), 128'(0));
        @(negedge clk);
        core_req = '0;
        fpu_gnt  = 1'b0;
        rst_n    = 1'b1;

        // Core 0 waits for the grant while core 1 also requests
        d_lat = 2; d_res = 32'h4000_0000; d_flags = 5'h02;
        for (int i = 0; i < 4; i++) begin
            drive_fpu();
            core_req = 3'b011;
            fpu_gnt  = 1'b0;
            run_cycle();
        end
        drive_fpu();
        core_req = 3'b011;
        fpu_gnt  = 1'b1;
        #1 check("t3_owner_gnt", 128'(core_gnt), 128'(3'b001));
        run_cycle();
        for (int i = 0; i < 8; i++) begin
            drive_fpu();
            fpu_gnt = 1'b1;
            run_cycle();
        end

        // Single core 1 request, immediate grant, three-cycle latency
        d_lat = 3; d_res = 32'h3F80_0000; d_flags = 5'h01;
        busy_seen = 0;
        drive_fpu();
        core_req = 3'b010;
        fpu_gnt  = 1'b1;
        run_cycle();
        for (int i = 0; i < 5; i++) begin
            drive_fpu();
            run_cycle();
        end
        check("t1_busy_cycles", 128'(busy_seen), 128'(3));

        // Cores 0 and 1 request continuously, FPU latency one
        hold_req = 1'b1;
        d_lat = 1; d_res = 32'h1234_5678; d_flags = 5'h04;
        gq.delete();
        for (int i = 0; i < 8; i++) begin
            drive_fpu();
            core_req = 3'b011;
            fpu_gnt  = 1'b1;
            run_cycle();
        end
        check("t2_grant_count", 128'(gq.size()), 128'(4));
        if (gq.size() == 4) begin
            check("t2_grant0", 128'(gq[0]), 128'(0));
            check("t2_grant1", 128'(gq[1]), 128'(1));
            check("t2_grant2", 128'(gq[2]), 128'(0));
            check("t2_grant3", 128'(gq[3]), 128'(1));
        end
        hold_req = 1'b0;
        core_req = '0;
        for (int i = 0; i < 3; i++) begin
            drive_fpu();
            run_cycle();
        end

        // FPU never answers: watchdog response and sticky fault
        d_lat = 0;
        drive_fpu();
        core_req = 3'b001;
        fpu_gnt  = 1'b1;
        run_cycle();
        for (int i = 0; i < 12; i++) begin
            drive_fpu();
            fpu_gnt = 1'b0;
            run_cycle();
        end
        #1 check("t4_fault_held", 128'(fpu_fault), 128'(1));
        drive_fpu();
        fault_clear = 1'b1;
        run_cycle();
        fault_clear = 1'b0;
        drive_fpu();
        run_cycle();

        // Stray rvalid while idle
        drive_fpu();
        fpu_rvalid = 1'b1;
        run_cycle();
        for (int i = 0; i < 2; i++) begin
            drive_fpu();
            run_cycle();
        end
        drive_fpu();
        fault_clear = 1'b1;
        run_cycle();
        fault_clear = 1'b0;

        // Asynchronous reset in the middle of an operation
        d_lat = 0;
        drive_fpu();
        core_req = 3'b110;
        fpu_gnt  = 1'b1;
        run_cycle();
        for (int i = 0; i < 2; i++) begin
            drive_fpu();
            core_req = 3'b011;
            fpu_gnt  = 1'b1;
            run_cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 128'(busy), 128'(0));
        check("t6_rst_fpu_req", 128'(fpu_req), 128'(0));
        check("t6_rst_gnt", 128'(core_gnt), 128'(0));
        check("t6_rst_rvalid", 128'(core_rvalid), 128'(0));
        check("t6_rst_ops", 128'(fpu_ops), 128'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_fpu();
        core_req = 3'b011;
        fpu_gnt  = 1'b1;
        d_lat = 2;
        #1 check("t6_first_winner", 128'(core_gnt), 128'(3'b001));
        run_cycle();
        for (int i = 0; i < 6; i++) begin
            drive_fpu();
            run_cycle();
        end

        // Randomized traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive_rand();
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
